mipsfpga_ahb_dma: RTL and testbench



---
 rtl/mipsfpga_ahb_pkg.sv | 27 ++
 rtl/mipsfpga_ahb_dma.sv | 169 ++++++++++++++++
 tb/tb_mipsfpga_ahb_dma.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mipsfpga_ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mipsfpga_ahb_pkg
// Purpose  : AHB encodings and the DMA master state enum.
// Revision : 1.0  initial release
// ============================================================================
package mipsfpga_ahb_pkg;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;
    localparam logic [2:0]  HBURST_SINGLE = 3'b000;
    localparam logic [3:0]  HPROT_DATA    = 4'b0011;
    localparam logic [31:0] WORD_STRIDE   = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_WR_ADDR = 3'd4,
        ST_WR_DATA = 3'd5,
        ST_DONE    = 3'd6
    } dma_state_t;

endpackage
`default_nettype wire

// File: rtl/mipsfpga_ahb_dma.sv
`default_nettype none
// ============================================================================
// Module   : mipsfpga_ahb_dma
// Purpose  : Word-by-word memory-to-memory copy engine on an AHB master port.
//            Define MIPSFPGA_DMA_LOCK_EN to lock the bus for the whole copy.
// Revision : 1.0  initial release
// ============================================================================
module mipsfpga_ahb_dma
    import mipsfpga_ahb_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        dma_start,
    input  logic [31:0] dma_src,
    input  logic [31:0] dma_dst,
    input  logic [15:0] dma_len,
    output logic        dma_busy,
    output logic        dma_done,
    output logic        dma_err,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    output logic        HBUSREQ,
    output logic        HLOCK,
    input  logic        HGRANT,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP
);

    dma_state_t  r_state;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [15:0] r_len;
    logic [31:0] r_hold;
    logic [31:0] r_haddr;
    logic [31:0] r_hwdata;
    logic        r_hwrite;
    logic        r_busreq;
    logic        r_done;
    logic        r_err;

    logic        w_addr_phase;
    logic        w_addr_done;
    logic        w_data_err;

    assign w_addr_phase = (r_state == ST_RD_ADDR) || (r_state == ST_WR_ADDR);
    assign w_addr_done  = w_addr_phase && HGRANT && HREADY;
    assign w_data_err   = HREADY && HRESP;

    // HTRANS follows HGRANT in the same cycle so the transfer starts the
    // moment ownership is granted.
    assign HTRANS   = (w_addr_phase && HGRANT) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HSIZE    = HSIZE_WORD;
    assign HBURST   = HBURST_SINGLE;
    assign HPROT    = HPROT_DATA;
    assign HADDR    = r_haddr;
    assign HWRITE   = r_hwrite;
    assign HWDATA   = r_hwdata;
    assign HBUSREQ  = r_busreq;
    assign dma_busy = (r_state != ST_IDLE);
    assign dma_done = r_done;
    assign dma_err  = r_err;

`ifdef MIPSFPGA_DMA_LOCK_EN
    assign HLOCK = r_busreq;
`else
    assign HLOCK = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state  <= ST_IDLE;
            r_src    <= '0;
            r_dst    <= '0;
            r_len    <= '0;
            r_hold   <= '0;
            r_haddr  <= '0;
            r_hwdata <= '0;
            r_hwrite <= 1'b0;
            r_busreq <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (dma_start) begin
                        r_err <= 1'b0;
                        if (dma_len != 16'd0) begin
                            r_src    <= dma_src;
                            r_dst    <= dma_dst;
                            r_len    <= dma_len;
                            r_busreq <= 1'b1;
                            r_state  <= ST_REQ;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    r_haddr  <= r_src;
                    r_hwrite <= 1'b0;
                    r_state  <= ST_RD_ADDR;
                end
                ST_RD_ADDR: begin
                    if (w_addr_done) begin
                        r_state <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (w_data_err) begin
                        r_busreq <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (HREADY) begin
                        r_hold   <= HRDATA;
                        r_haddr  <= r_dst;
                        r_hwrite <= 1'b1;
                        r_state  <= ST_WR_ADDR;
                    end
                end
                ST_WR_ADDR: begin
                    if (w_addr_done) begin
                        r_hwdata <= r_hold;
                        r_state  <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (w_data_err) begin
                        r_busreq <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (HREADY) begin
                        r_src <= r_src + WORD_STRIDE;
                        r_dst <= r_dst + WORD_STRIDE;
                        r_len <= r_len - 16'd1;
                        // Pre-decrement length of one means this was the last word.
                        if (r_len == 16'd1) begin
                            r_busreq <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_haddr  <= r_src + WORD_STRIDE;
                            r_hwrite <= 1'b0;
                            r_state  <= ST_RD_ADDR;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busreq <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mipsfpga_ahb_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_mipsfpga_ahb_dma
// Purpose  : Self-checking bench for mipsfpga_ahb_dma with a behavioural AHB
//            slave/arbiter and a copy-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mipsfpga_ahb_dma;

`ifdef MIPSFPGA_DMA_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        logic        err;
    } xfer_t;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        dma_start;
    logic [31:0] dma_src;
    logic [31:0] dma_dst;
    logic [15:0] dma_len;
    logic        dma_busy;
    logic        dma_done;
    logic        dma_err;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HBUSREQ;
    logic        HLOCK;
    logic        HGRANT;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;

    mipsfpga_ahb_dma dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .dma_start (dma_start),
        .dma_src   (dma_src),
        .dma_dst   (dma_dst),
        .dma_len   (dma_len),
        .dma_busy  (dma_busy),
        .dma_done  (dma_done),
        .dma_err   (dma_err),
        .HADDR     (HADDR),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HSIZE     (HSIZE),
        .HTRANS    (HTRANS),
        .HWDATA    (HWDATA),
        .HWRITE    (HWRITE),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HGRANT    (HGRANT),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Slave / arbiter configuration
    int deny_left  = 0;
    bit grant_rand = 1'b0;
    bit wait_rand  = 1'b0;
    int rd_wait    = 0;
    int wr_wait    = 0;
    int err_phase  = -1;

    // Observations
    int          cycle = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          done_cycle = -1;
    logic        last_err = 1'b0;
    bit          prev_done = 1'b0;
    int          busy_cnt = 0;
    bit          busreq_seen = 1'b0;
    int          first_busreq = -1;
    int          nonseq_cnt = 0;
    int          nonseq_cyc[$];
    int          phase_idx = 0;
    int          start_cyc = 0;
    bit          pend_valid = 1'b0;
    bit          pend_write = 1'b0;
    logic [31:0] pend_addr = '0;
    int          wait_left = 0;
    xfer_t       xlog[$];
    bit [31:0]   mem [bit [31:0]];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    // Bus slave, arbiter and protocol monitor: inputs change on the falling edge,
    // DUT outputs are sampled 1 time unit later.
    initial begin
        HGRANT = 1'b1;
        HREADY = 1'b1;
        HRDATA = '0;
        HRESP  = 1'b0;
        forever begin
            @(negedge HCLK);
            if (deny_left > 0 && HBUSREQ === 1'b1) begin
                HGRANT = 1'b0;
                deny_left--;
            end else if (grant_rand) begin
                HGRANT = ($urandom_range(0, 3) != 0);
            end else begin
                HGRANT = 1'b1;
            end
            HRESP  = 1'b0;
            HRDATA = $urandom;
            if (pend_valid && wait_left > 0) begin
                HREADY = 1'b0;
                wait_left--;
            end else begin
                HREADY = 1'b1;
                if (pend_valid && !pend_write) HRDATA = mem_read(pend_addr);
                if (pend_valid && phase_idx == err_phase) HRESP = 1'b1;
            end
            #1;
            cycle++;
            if (HTRANS !== 2'b00 && HTRANS !== 2'b10) bad++;
            if (HTRANS === 2'b10 && (!HGRANT || pend_valid)) bad++;
            if (HBUSREQ !== (dma_busy && !dma_done)) bad++;
            if (HLOCK !== (LOCK_EN && dma_busy && !dma_done)) bad++;
            if ({HSIZE, HBURST, HPROT} !== 10'b010_000_0011) bad++;
            if (dma_done === 1'b1) begin
                if (prev_done) bad++;
                done_cnt++;
                done_cycle = cycle;
                last_err   = dma_err;
            end
            prev_done = (dma_done === 1'b1);
            if (dma_busy === 1'b1) busy_cnt++;
            if (HBUSREQ === 1'b1 && !busreq_seen) begin
                busreq_seen  = 1'b1;
                first_busreq = cycle;
            end
            if (HRESET) begin
                pend_valid = 1'b0;
            end else if (HREADY) begin
                if (pend_valid) begin
                    xlog.push_back({pend_addr, pend_write, pend_write ? HWDATA : HRDATA, HRESP});
                    if (pend_write && !HRESP) mem[pend_addr] = HWDATA;
                    phase_idx++;
                    pend_valid = 1'b0;
                end
                if (HTRANS === 2'b10) begin
                    pend_valid = 1'b1;
                    pend_addr  = HADDR;
                    pend_write = HWRITE;
                    wait_left  = wait_rand ? int'($urandom_range(0, 2)) : (HWRITE ? wr_wait : rd_wait);
                    nonseq_cnt++;
                    nonseq_cyc.push_back(cycle);
                end
            end
        end
    end

    // Run one copy and compare the observed bus traffic with the expected
    // read/write sequence of a word copy (optionally cut short by an error).
    task automatic run_copy(input string name, input logic [31:0] src, input logic [31:0] dst,
                            input int nl, input int err_ph);
        logic [31:0] sdata[$];
        logic [31:0] d;
        int          n_exp;
        bit          exp_err;
        xfer_t       e;
        int          i;
        for (int k = 0; k < nl; k++) begin
            d = $urandom;
            mem[src + 32'(4 * k)] = d;
            sdata.push_back(d);
        end
        exp_err = (err_ph >= 0 && err_ph < 2 * nl);
        n_exp   = exp_err ? err_ph + 1 : 2 * nl;
        xlog.delete();
        nonseq_cyc.delete();
        bad = 0; done_cnt = 0; busy_cnt = 0; busreq_seen = 1'b0; first_busreq = -1;
        done_cycle = -1; phase_idx = 0; nonseq_cnt = 0; err_phase = err_ph;
        dma_src = src; dma_dst = dst; dma_len = 16'(nl); dma_start = 1'b1;
        start_cyc = cycle;
        @(negedge HCLK); #2;
        dma_start = 1'b0;
        for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
            @(negedge HCLK); #2;
        end
        repeat (3) begin
            @(negedge HCLK); #2;
        end
        n_checks++;
        if (done_cnt !== 1) $display("FAIL %s done_count: got %0d expected 1", name, done_cnt);
        else n_pass++;
        n_checks++;
        if (last_err !== exp_err) $display("FAIL %s dma_err: got %b expected %b", name, last_err, exp_err);
        else n_pass++;
        n_checks++;
        if (xlog.size() != n_exp) $display("FAIL %s xfer_count: got %0d expected %0d", name, xlog.size(), n_exp);
        else n_pass++;
        for (int p = 0; p < n_exp && p < xlog.size(); p++) begin
            i = p / 2;
            e.addr = (p % 2 == 0) ? src + 32'(4 * i) : dst + 32'(4 * i);
            e.wr   = (p % 2 == 1);
            e.data = sdata[i];
            e.err  = (p == err_ph);
            n_checks++;
            if (xlog[p] !== e) $display("FAIL %s xfer%0d: got %h expected %h", name, p, xlog[p], e);
            else n_pass++;
        end
        n_checks++;
        if (nonseq_cnt != n_exp) $display("FAIL %s nonseq_count: got %0d expected %0d", name, nonseq_cnt, n_exp);
        else n_pass++;
        n_checks++;
        if (bad != 0) $display("FAIL %s protocol_violations: got %0d expected 0", name, bad);
        else n_pass++;
        n_checks++;
        if (dma_busy !== 1'b0) $display("FAIL %s busy_after: got %b expected 0", name, dma_busy);
        else n_pass++;
    endtask

    task automatic test_reset;
        HRESET = 1'b1;
        repeat (3) begin
            @(negedge HCLK); #2;
        end
        n_checks++;
        if ({HTRANS, HBUSREQ, HLOCK, HADDR, HWRITE, HWDATA} !== 69'd0)
            $display("FAIL reset_bus: got %h expected 0", {HTRANS, HBUSREQ, HLOCK, HADDR, HWRITE, HWDATA});
        else n_pass++;
        n_checks++;
        if ({dma_busy, dma_done, dma_err} !== 3'b000)
            $display("FAIL reset_status: got %b expected 000", {dma_busy, dma_done, dma_err});
        else n_pass++;
        n_checks++;
        if ({HSIZE, HBURST, HPROT} !== 10'b010_000_0011)
            $display("FAIL reset_attrs: got %b expected 0100000011", {HSIZE, HBURST, HPROT});
        else n_pass++;
        HRESET = 1'b0;
        @(negedge HCLK); #2;
    endtask

    task automatic test_basic;
        grant_rand = 1'b0; wait_rand = 1'b0; rd_wait = 0; wr_wait = 0;
        run_copy("basic", 32'h100, 32'h200, 2, -1);
    endtask

    task automatic test_zero_len;
        run_copy("zero_len", 32'h500, 32'h600, 0, -1);
        n_checks++;
        if (busreq_seen) $display("FAIL zero_len busreq: got 1 expected 0");
        else n_pass++;
        n_checks++;
        if (done_cycle != start_cyc + 1)
            $display("FAIL zero_len done_time: got %0d expected %0d", done_cycle, start_cyc + 1);
        else n_pass++;
        n_checks++;
        if (busy_cnt != 1) $display("FAIL zero_len busy_cycles: got %0d expected 1", busy_cnt);
        else n_pass++;
    endtask

    task automatic test_grant_delay;
        int gap;
        deny_left = 5;
        run_copy("grant_delay", 32'h1000, 32'h2000, 1, -1);
        gap = (nonseq_cyc.size() > 0) ? nonseq_cyc[0] - first_busreq : -1;
        n_checks++;
        if (gap != 5) $display("FAIL grant_delay first_nonseq: got %0d expected 5", gap);
        else n_pass++;
    endtask

    task automatic test_wait_states;
        int gap;
        rd_wait = 3; wr_wait = 0;
        run_copy("wait_states", 32'h3000, 32'h3800, 2, -1);
        gap = (nonseq_cyc.size() > 1) ? nonseq_cyc[1] - nonseq_cyc[0] : -1;
        n_checks++;
        if (gap != 5) $display("FAIL wait_states wr_addr_time: got %0d expected 5", gap);
        else n_pass++;
        rd_wait = 0;
    endtask

    task automatic test_error;
        run_copy("error", 32'h4000, 32'h4800, 4, 1);
    endtask

    task automatic test_random;
        int nl;
        int errp;
        logic [31:0] src;
        grant_rand = 1'b1; wait_rand = 1'b1;
        run_copy("wrap", 32'hFFFF_FFF8, 32'h7FFF_FFF8, 4, -1);
        for (int k = 0; k < 8; k++) begin
            nl   = int'($urandom_range(1, 6));
            src  = $urandom & 32'hFFFF_FFFC;
            errp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * nl - 1)) : -1;
            run_copy($sformatf("rand%0d", k), src, src ^ 32'h8000_0000, nl, errp);
        end
        grant_rand = 1'b0; wait_rand = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit found;
        wr_wait = 3; err_phase = -1; done_cnt = 0;
        found = 1'b0;
        dma_src = 32'h5000; dma_dst = 32'h5800; dma_len = 16'd3; dma_start = 1'b1;
        @(negedge HCLK); #2;
        dma_start = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge HCLK); #2;
            if (pend_valid && pend_write) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL reset_mid reach_wr_data: got 0 expected 1");
        else n_pass++;
        HRESET = 1'b1;
        @(negedge HCLK); #2;
        n_checks++;
        if ({HTRANS, HBUSREQ, HLOCK, HADDR, HWRITE, HWDATA} !== 69'd0)
            $display("FAIL reset_mid bus: got %h expected 0", {HTRANS, HBUSREQ, HLOCK, HADDR, HWRITE, HWDATA});
        else n_pass++;
        n_checks++;
        if ({dma_busy, dma_done, dma_err} !== 3'b000)
            $display("FAIL reset_mid status: got %b expected 000", {dma_busy, dma_done, dma_err});
        else n_pass++;
        HRESET = 1'b0;
        repeat (5) begin
            @(negedge HCLK); #2;
        end
        n_checks++;
        if (done_cnt != 0 || dma_busy !== 1'b0)
            $display("FAIL reset_mid no_done: got done=%0d busy=%b expected 0/0", done_cnt, dma_busy);
        else n_pass++;
        wr_wait = 0;
    endtask

    initial begin
        HRESET    = 1'b1;
        dma_start = 1'b0;
        dma_src   = '0;
        dma_dst   = '0;
        dma_len   = '0;
        test_reset();
        test_basic();
        test_zero_len();
        test_grant_delay();
        test_wait_states();
        test_error();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
